// File: rtl/branch_redirect_ctrl.sv
// Front-end recovery controller: compares the EX-stage branch/jump outcome with the
// fetch prediction, issues a held PC redirect, flushes IF/ID, and keeps branch statistics.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ex_valid_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_is_jump_i,
  input  logic             ex_taken_i,
  input  logic             ex_pred_taken_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             redirect_ready_i,
  input  logic             clr_stats_i,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  // Redirect handshake: redirect_valid_o stays high and redirect_pc_o stays stable until
  // a cycle where redirect_ready_i is also high; that cycle is the single transfer.
  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  logic            ev, act, mis;
  logic [XLEN-1:0] correct_pc;

  assign ev         = ex_valid_i & (ex_is_branch_i | ex_is_jump_i);
  assign act        = ex_is_jump_i ? 1'b1 : ex_taken_i;
  assign mis        = ev & (act != ex_pred_taken_i);
  assign correct_pc = act ? ex_target_i : ex_pc_i + XLEN'(4);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pc_q        <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_d        = pc_q;
    case (state_q)
      IDLE: begin
        if (mis) begin
          pc_d    = correct_pc;
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d     = FLUSH;
            flush_cnt_d = CW'(FLUSH_CYCLES);
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q <= CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Events are only meaningful in IDLE; anything seen during recovery is wrong-path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (clr_stats_i) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (ev && br_cnt_q != {CNT_W{1'b1}})  br_cnt_q  <= br_cnt_q + 1'b1;
      if (mis && mis_cnt_q != {CNT_W{1'b1}}) mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign redirect_valid_o = (state_q == REDIRECT);
  assign flush_o          = (state_q != IDLE);
  assign busy_o           = (state_q != IDLE);
  assign redirect_pc_o    = pc_q;
  assign br_count_o       = br_cnt_q;
  assign mispred_count_o  = mis_cnt_q;

endmodule
